// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage of the pipelined MIPS core. It owns the program
// counter and the IF/ID pipeline register. It consumes the PCSrc / ID_Flush
// pair produced by the jump unit in ID, and it keeps two saturating
// performance counters.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   Defined   : a misaligned next PC is replaced by EXC_VECTOR, and the sticky
//               Fetch_Misalign output is present.
//   Undefined : targets load unmodified, and there is no Fetch_Misalign port.
//
// Parameters
//   RESET_VECTOR   PC value loaded on reset.
//   EXC_VECTOR     redirect target for a misaligned fetch (align check only).
//
// Ports
//   clk            in   1   pipeline clock, rising edge
//   rst            in   1   asynchronous, active-high reset
//   PCSrc          in   2   0 = PC+4, 1 = branch, 2 = J/JAL, 3 = JR
//   ID_Flush       in   1   bubble IF/ID on this edge
//   Stall          in   1   load-use hazard: hold PC and IF/ID
//   BranchImm      in  16   branch immediate of the instruction in ID
//   JumpIdx        in  26   instr_index of the instruction in ID
//   RegTarget      in  32   forwarded rs value for JR
//   IMem_Data      in  32   instruction word, combinational from IF_PC
//   IF_PC          out 32   current fetch address
//   ID_Instr       out 32   IF/ID instruction (0 = nop bubble)
//   ID_PC4         out 32   IF/ID PC+4
//   ID_Valid       out  1   IF/ID holds a real instruction
//   RedirectCount  out 32   taken redirects, saturating
//   StallCount     out 32   stall cycles, saturating
//   Fetch_Misalign out  1   sticky misalignment flag (align check only)
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic        ID_Flush,
  input  logic        Stall,
  input  logic [15:0] BranchImm,
  input  logic [25:0] JumpIdx,
  input  logic [31:0] RegTarget,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC4,
  output logic        ID_Valid,
  output logic [31:0] RedirectCount,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic [31:0] StallCount,
  output logic        Fetch_Misalign
`else
  output logic [31:0] StallCount
`endif
);

  // Next-PC source encoding as driven by the jump unit.
  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_JR     = 2'd3
  } pc_src_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Architectural state
  logic [31:0] pc_q,           pc_d;
  logic [31:0] id_instr_q,     id_instr_d;
  logic [31:0] id_pc4_q,       id_pc4_d;
  logic        id_valid_q,     id_valid_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q,    stall_cnt_d;

  // Target computation
  pc_src_e     pc_src;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] sel_tgt;
  logic        redirect;
  logic        bubble;

  assign pc_src   = pc_src_e'(PCSrc);
  assign pc_plus4 = pc_q + 32'd4;

  // Branch offset: sign-extended immediate scaled to a word offset. The
  // base is the PC+4 of the branch itself, which is what IF/ID holds.
  assign branch_off = {{14{BranchImm[15]}}, BranchImm, 2'b00};
  assign branch_tgt = id_pc4_q + branch_off;

  // J/JAL keep the 256 MB region of the delay-slot-free PC+4.
  assign jump_tgt   = {id_pc4_q[31:28], JumpIdx, 2'b00};

  always_comb begin
    sel_tgt = pc_plus4;
    unique case (pc_src)
      SRC_SEQ:    sel_tgt = pc_plus4;
      SRC_BRANCH: sel_tgt = branch_tgt;
      SRC_JUMP:   sel_tgt = jump_tgt;
      SRC_JR:     sel_tgt = RegTarget;
      default:    sel_tgt = pc_plus4;
    endcase
  end

  // Any taken redirect forces a bubble, whether or not ID_Flush is raised,
  // because the sequentially fetched word belongs to the wrong path.
  assign redirect = (PCSrc != 2'd0);
  assign bubble   = redirect | ID_Flush;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic tgt_misaligned;

  assign tgt_misaligned = (sel_tgt[1:0] != 2'b00);
`else
  // EXC_VECTOR only matters when the align check is built in.
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    pc_d           = pc_q;
    id_instr_d     = id_instr_q;
    id_pc4_d       = id_pc4_q;
    id_valid_d     = id_valid_q;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d     = misalign_q;
`endif

    if (Stall) begin
      // Hold everything. PCSrc/ID_Flush are deliberately ignored: the jump
      // unit will present the same decision again once ID is re-presented.
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end else begin
      pc_d     = sel_tgt;
      id_pc4_d = pc_plus4;

`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt_misaligned) begin
        pc_d       = EXC_VECTOR;
        misalign_d = 1'b1;
      end
`endif

      if (bubble) begin
        id_instr_d = 32'd0;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d = IMem_Data;
        id_valid_d = 1'b1;
      end

      // A bare ID_Flush is not a redirect and is not counted.
      if (redirect && (redirect_cnt_q != CNT_MAX)) begin
        redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_VECTOR;
      id_instr_q     <= 32'd0;
      id_pc4_q       <= 32'd0;
      id_valid_q     <= 1'b0;
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      pc_q           <= pc_d;
      id_instr_q     <= id_instr_d;
      id_pc4_q       <= id_pc4_d;
      id_valid_q     <= id_valid_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign Fetch_Misalign = misalign_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign IF_PC         = pc_q;
  assign ID_Instr      = id_instr_q;
  assign ID_PC4        = id_pc4_q;
  assign ID_Valid      = id_valid_q;
  assign RedirectCount = redirect_cnt_q;
  assign StallCount    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed vectors, a spec-level reference
// model, and hand-computed literal expectations.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrc;
  logic        ID_Flush;
  logic        Stall;
  logic [15:0] BranchImm;
  logic [25:0] JumpIdx;
  logic [31:0] RegTarget;
  logic [31:0] IMem_Data;
  logic [31:0] IF_PC;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PC4;
  logic        ID_Valid;
  logic [31:0] RedirectCount;
  logic [31:0] StallCount;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        Fetch_Misalign;
`endif

  int n_total = 0;
  int n_bad   = 0;

  fetch_pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc         (PCSrc),
    .ID_Flush      (ID_Flush),
    .Stall         (Stall),
    .BranchImm     (BranchImm),
    .JumpIdx       (JumpIdx),
    .RegTarget     (RegTarget),
    .IMem_Data     (IMem_Data),
    .IF_PC         (IF_PC),
    .ID_Instr      (ID_Instr),
    .ID_PC4        (ID_PC4),
    .ID_Valid      (ID_Valid),
    .RedirectCount (RedirectCount),
`ifdef FETCH_ALIGN_CHECK_EN
    .StallCount    (StallCount),
    .Fetch_Misalign(Fetch_Misalign)
`else
    .StallCount    (StallCount)
`endif
  );

  // Instruction memory: each word is the bitwise inverse of its address.
  assign IMem_Data = ~IF_PC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model (spec rules, plain arithmetic)
  // ---------------------------------------------------------------------
  logic [31:0] m_pc, m_instr, m_pc4, m_rc, m_sc;
  logic        m_valid, m_mis;
  logic        preset_req = 1'b0;
  logic [31:0] m_tgt;
  longint      m_off;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_rc = 32'h0; m_sc = 32'h0; m_mis = 1'b0;
    end else begin
      if (preset_req) m_rc = 32'hFFFF_FFFE;
      if (Stall) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else begin
        m_off = longint'($signed(BranchImm)) * 4;
        case (PCSrc)
          2'd0: m_tgt = m_pc + 4;
          2'd1: m_tgt = 32'(longint'(m_pc4) + m_off);
          2'd2: m_tgt = (m_pc4 & 32'hF000_0000) + (32'(JumpIdx) * 4);
          default: m_tgt = RegTarget;
        endcase
        m_pc4 = m_pc + 4;
        if (PCSrc != 0 || ID_Flush) begin
          m_instr = 32'h0; m_valid = 1'b0;
        end else begin
          m_instr = ~m_pc; m_valid = 1'b1;
        end
        if (PCSrc != 0 && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
`ifdef FETCH_ALIGN_CHECK_EN
        if (m_tgt % 4 != 0) begin
          m_tgt = 32'h0000_0180;
          m_mis = 1'b1;
        end
`endif
        m_pc = m_tgt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model_if_pc",    IF_PC,         m_pc);
    chk("model_id_instr", ID_Instr,      m_instr);
    chk("model_id_pc4",   ID_PC4,        m_pc4);
    chk("model_id_valid", 32'(ID_Valid), 32'(m_valid));
    chk("model_redir",    RedirectCount, m_rc);
    chk("model_stall",    StallCount,    m_sc);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("model_misalign", 32'(Fetch_Misalign), 32'(m_mis));
`endif
  endtask

  // Apply one set of inputs across one active edge, then compare at the
  // following negedge + 1.
  task automatic cyc(input logic [1:0] src, input logic fl, input logic st,
                     input logic [15:0] imm, input logic [25:0] idx,
                     input logic [31:0] rt);
    PCSrc = src; ID_Flush = fl; Stall = st;
    BranchImm = imm; JumpIdx = idx; RegTarget = rt;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("cycle: PCSrc=%0d flush=%0b stall=%0b -> IF_PC=%08h ID_Instr=%08h ID_PC4=%08h V=%0b RC=%0d SC=%0d",
             src, fl, st, IF_PC, ID_Instr, ID_PC4, ID_Valid, RedirectCount, StallCount);
    compare_model();
  endtask

  task automatic seq();
    cyc(2'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    PCSrc = 2'd0; ID_Flush = 1'b0; Stall = 1'b0;
    BranchImm = 16'h0; JumpIdx = 26'h0; RegTarget = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    compare_model();
    chk("reset_if_pc", IF_PC, 32'h0);
    chk("reset_valid", 32'(ID_Valid), 32'h0);
    rst = 1'b0;

    // Sequential fetch after release
    seq();
    chk("seq1_if_pc", IF_PC, 32'h4);
    chk("seq1_pc4",   ID_PC4, 32'h4);
    chk("seq1_instr", ID_Instr, 32'hFFFF_FFFF);
    chk("seq1_valid", 32'(ID_Valid), 32'h1);
    seq();
    chk("seq2_if_pc", IF_PC, 32'h8);
    chk("seq2_pc4",   ID_PC4, 32'h8);
    seq();
    chk("seq3_if_pc", IF_PC, 32'hC);

    // Reset asserted mid-cycle takes effect immediately
    #2 rst = 1'b1;
    #1;
    chk("midrst_if_pc", IF_PC, 32'h0);
    chk("midrst_valid", 32'(ID_Valid), 32'h0);
    chk("model_midrst_pc", m_pc, 32'h0);
    @(negedge clk); #1;
    compare_model();
    rst = 1'b0;

    // Walk to ID_PC4 = 0x104 sequentially
    for (int i = 0; i < 65; i++) seq();
    chk("walk_if_pc", IF_PC, 32'h104);
    chk("walk_pc4",   ID_PC4, 32'h104);

    // Taken backward branch: 0x104 + (-2 << 2) = 0xFC
    cyc(2'd1, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    chk("br_if_pc", IF_PC, 32'hFC);
    chk("br_valid", 32'(ID_Valid), 32'h0);
    chk("br_redir", RedirectCount, 32'h1);
    chk("model_br_pc", m_pc, 32'hFC);
    seq();
    chk("br_next_pc",    IF_PC, 32'h100);
    chk("br_next_instr", ID_Instr, 32'hFFFF_FF03);
    chk("br_next_valid", 32'(ID_Valid), 32'h1);

    // JR then J
    cyc(2'd3, 1'b1, 1'b0, 16'h0, 26'h0, 32'h1000_000C);
    chk("jr0_if_pc", IF_PC, 32'h1000_000C);
    seq();
    chk("j_pre_pc4", ID_PC4, 32'h1000_0010);
    cyc(2'd2, 1'b1, 1'b0, 16'h0, 26'h000_0040, 32'h0);
    chk("j_if_pc", IF_PC, 32'h1000_0100);
    chk("model_j_pc", m_pc, 32'h1000_0100);
    cyc(2'd3, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0040_0020);
    chk("jr_if_pc", IF_PC, 32'h0040_0020);
    chk("jr_redir", RedirectCount, 32'h4);
    seq();
    chk("jr_next_instr", ID_Instr, 32'hFFBF_FFDF);

    // Stall versus redirect: stall wins for three cycles
    for (int i = 0; i < 3; i++) cyc(2'd2, 1'b1, 1'b1, 16'h0, 26'h000_0040, 32'h0);
    chk("stall_if_pc", IF_PC, 32'h0040_0024);
    chk("stall_instr", ID_Instr, 32'hFFBF_FFDF);
    chk("stall_cnt",   StallCount, 32'h3);
    chk("stall_redir", RedirectCount, 32'h4);
    cyc(2'd2, 1'b1, 1'b0, 16'h0, 26'h000_0040, 32'h0);
    chk("unstall_if_pc", IF_PC, 32'h100);
    chk("unstall_redir", RedirectCount, 32'h5);

    // Bare flush: bubble, sequential PC, not a redirect
    cyc(2'd0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("flush_if_pc", IF_PC, 32'h104);
    chk("flush_valid", 32'(ID_Valid), 32'h0);
    chk("flush_redir", RedirectCount, 32'h5);

    // Counter saturation
    force dut.redirect_cnt_q = 32'hFFFF_FFFE;
    preset_req = 1'b1;
    #1;
    release dut.redirect_cnt_q;
    cyc(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h200);
    preset_req = 1'b0;
    chk("sat1_redir", RedirectCount, 32'hFFFF_FFFF);
    cyc(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h200);
    cyc(2'd3, 1'b0, 1'b0, 16'h0, 26'h0, 32'h200);
    chk("sat3_redir", RedirectCount, 32'hFFFF_FFFF);

    // Misaligned JR target
    seq();
    cyc(2'd3, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0040_0022);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_if_pc", IF_PC, 32'h180);
    chk("mis_flag",  32'(Fetch_Misalign), 32'h1);
    seq();
    chk("mis_sticky", 32'(Fetch_Misalign), 32'h1);
    chk("mis_next_pc", IF_PC, 32'h184);
`else
    chk("mis_if_pc", IF_PC, 32'h0040_0022);
    seq();
    chk("mis_next_pc", IF_PC, 32'h0040_0026);
`endif

    // Final reset clears everything
    #2 rst = 1'b1;
    #1;
    chk("rst2_redir", RedirectCount, 32'h0);
    chk("rst2_stall", StallCount, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst2_misalign", 32'(Fetch_Misalign), 32'h0);
`endif
    @(negedge clk); #1;
    rst = 1'b0;
    seq();
    chk("rst2_if_pc", IF_PC, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
